// File: rtl/i2c_mux_arbiter.sv
// Round-robin arbiter sharing one TCA9546A mux driver (and the I2C bus behind it)
// among NUM_REQ requesters; reprograms the mux only when the winner's channel differs.
module i2c_mux_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] req_channel,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 mux_update,
    output logic [2:0]           mux_channel,
    input  logic                 mux_busy,
    output logic [2:0]           cur_channel,
    output logic                 cur_valid,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_SELECT,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d, rr_q, rr_d;
    logic [IDX_W-1:0]   pick_idx, scan_idx, winner_next;
    logic               pick_found;
    logic [2:0]         pick_chan;
    logic [2:0]         chan_q, chan_d, cur_channel_d;
    logic               cur_valid_d, timeout_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_d;

    // First active request at or above the round-robin pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = rr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
        pick_chan = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_chan = req_channel[3*i +: 3];
        end
    end

    assign winner_next = (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;

    // NOTE: every signal gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        chan_d        = chan_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        cur_channel_d = cur_channel;
        cur_valid_d   = cur_valid;
        timeout_err_d = timeout_err;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    winner_d = pick_idx;
                    chan_d   = pick_chan;
                    state_d  = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (!(cur_valid && cur_channel == chan_q)) begin
                    state_d = S_SELECT;
                end else if (req[winner_q]) begin
                    state_d = S_GRANT;
                end else begin
                    rr_d    = winner_next;
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                cur_valid_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (mux_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    cur_valid_d   = 1'b0;
                    rr_d          = winner_next;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!mux_busy) begin
                    cur_channel_d = chan_q;
                    cur_valid_d   = 1'b1;
                    // A requester that gave up mid-programming still leaves the mux cache valid.
                    if (req[winner_q]) begin
                        state_d = S_GRANT;
                    end else begin
                        rr_d    = winner_next;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    cur_valid_d   = 1'b0;
                    rr_d          = winner_next;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GRANT: begin
                if (!req[winner_q]) begin
                    rr_d    = winner_next;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        grant_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_d[i] = (state_d == S_GRANT) && (winner_d == IDX_W'(i));
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            winner_q    <= '0;
            chan_q      <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            grant       <= '0;
            mux_update  <= 1'b0;
            mux_channel <= '0;
            cur_channel <= '0;
            cur_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            chan_q      <= chan_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            grant       <= grant_d;
            mux_update  <= (state_d == S_SELECT);
            cur_channel <= cur_channel_d;
            cur_valid   <= cur_valid_d;
            timeout_err <= timeout_err_d;
            if (state_d == S_SELECT) mux_channel <= chan_d;
        end
    end

endmodule
